// File: rtl/burst_pkg.sv
// Shared types for the burst store-and-forward FIFO.
// Holds the FSM state enum used by burst_store_fwd_fifo. Size parameters
// stay local to each module.
package burst_pkg;

  typedef enum logic [0:0] {
    STORE       = 1'b0,
    CUT_THROUGH = 1'b1
  } burst_state_e;

endpackage

// File: rtl/decoupled_burst_intr.sv
// Decoupled beat stream: valid/ready handshake plus a last-beat marker.
//   master: drives valid/last/data, samples ready
//   slave : samples valid/last/data, drives ready
interface decoupled_burst_intr #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic                  last;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output last, output data, input ready);
  modport slave  (input valid, input last, input data, output ready);
endinterface

// File: rtl/burst_fifo_mem.sv
// Storage array for the burst FIFO: DEPTH entries of WIDTH bits,
// one synchronous write port and one asynchronous read port.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data (combinational from raddr)
// Contents are not reset; the FIFO pointers define what is valid.
module burst_fifo_mem #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 33,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/burst_store_fwd_fifo.sv
// Store-and-forward burst FIFO. Beats are buffered until the last beat of
// their burst is stored, then released. A burst larger than the buffer
// would deadlock, so when the buffer is full with no complete burst the
// FIFO switches to cut-through until that burst's last beat leaves.
// Ports:
//   clk, rst_n    - clock, synchronous active-low reset
//   in_burst      - beat stream in (slave)
//   out_burst     - beat stream out (master)
//   occupancy     - beats currently stored
//   bursts_stored - complete bursts held and not yet fully drained
//   cut_through   - high while forwarding an oversized burst
module burst_store_fwd_fifo
  import burst_pkg::*;
#(
  parameter  int DEPTH      = 16,
  parameter  int DATA_WIDTH = 32,
  localparam int CW         = $clog2(DEPTH + 1),
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  decoupled_burst_intr.slave    in_burst,
  decoupled_burst_intr.master   out_burst,
  output logic [CW-1:0]         occupancy,
  output logic [CW-1:0]         bursts_stored,
  output logic                  cut_through
);

  logic [AW-1:0]       wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]       occ_r, bursts_r;
  burst_state_e        state_r, state_s;
  logic                ct_open_r;
  logic                full_s, push_s, pop_s, out_valid_s;
  logic                push_last_s, pop_last_s, inc_s, dec_s;
  logic [DATA_WIDTH:0] rd_entry_s;

  burst_fifo_mem #(.DEPTH(DEPTH), .WIDTH(DATA_WIDTH + 1)) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata ({in_burst.last, in_burst.data}),
    .raddr (rd_ptr_r),
    .rdata (rd_entry_s)
  );

  // ready depends only on the registered count, never on valid
  assign full_s         = (occ_r == CW'(DEPTH));
  assign in_burst.ready = !full_s;
  assign push_s         = in_burst.valid && !full_s;
  assign pop_s          = out_valid_s && out_burst.ready;
  assign push_last_s    = push_s && in_burst.last;
  assign pop_last_s     = pop_s && rd_entry_s[DATA_WIDTH];

  // The oversized burst that forced cut-through never counts as complete:
  // its last beat is neither counted on push nor uncounted on pop.
  assign inc_s = push_last_s && !((state_r == CUT_THROUGH) && ct_open_r);
  assign dec_s = pop_last_s && (state_r == STORE);

  assign out_burst.valid = out_valid_s;
  assign out_burst.last  = rd_entry_s[DATA_WIDTH];
  assign out_burst.data  = rd_entry_s[DATA_WIDTH-1:0];
  assign occupancy       = occ_r;
  assign bursts_stored   = bursts_r;
  assign cut_through     = (state_r == CUT_THROUGH);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= STORE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      STORE: begin
        if (full_s && (bursts_r == {CW{1'b0}})) state_s = CUT_THROUGH;
        else                                     state_s = STORE;
      end
      CUT_THROUGH: begin
        if (pop_last_s) state_s = STORE;
        else            state_s = CUT_THROUGH;
      end
      default: state_s = STORE;
    endcase
  end

  // FSM output logic: when a beat may leave the buffer
  always_comb begin
    out_valid_s = 1'b0;
    case (state_r)
      STORE:       out_valid_s = (bursts_r != {CW{1'b0}});
      CUT_THROUGH: out_valid_s = (occ_r != {CW{1'b0}});
      default:     out_valid_s = 1'b0;
    endcase
  end

  // Pointers, occupancy, complete-burst count and oversized-burst tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r  <= {AW{1'b0}};
      rd_ptr_r  <= {AW{1'b0}};
      occ_r     <= {CW{1'b0}};
      bursts_r  <= {CW{1'b0}};
      ct_open_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + CW'(1'b1);
        2'b01:   occ_r <= occ_r - CW'(1'b1);
        default: occ_r <= occ_r;
      endcase
      case ({inc_s, dec_s})
        2'b10:   bursts_r <= bursts_r + CW'(1'b1);
        2'b01:   bursts_r <= bursts_r - CW'(1'b1);
        default: bursts_r <= bursts_r;
      endcase
      // Open on entering cut-through; closes when the oversized burst's
      // last beat arrives, so later bursts are counted normally.
      if (state_r == STORE)  ct_open_r <= (state_s == CUT_THROUGH);
      else if (push_last_s)  ct_open_r <= 1'b0;
      else                   ct_open_r <= ct_open_r;
    end
  end

endmodule

// File: tb/tb_burst_store_fwd_fifo.sv
module tb_burst_store_fwd_fifo;

  localparam int DEPTH = 16;
  localparam int DW    = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] occupancy, bursts_stored;
  logic       cut_through;

  always #5 clk = ~clk;

  decoupled_burst_intr #(.DATA_WIDTH(DW)) in_if ();
  decoupled_burst_intr #(.DATA_WIDTH(DW)) out_if ();

  burst_store_fwd_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_burst      (in_if),
    .out_burst     (out_if),
    .occupancy     (occupancy),
    .bursts_stored (bursts_stored),
    .cut_through   (cut_through)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [DW:0] src_q[$];
  logic [DW:0] exp_q[$];
  int mocc, ct_seen, first_pop, last_pop, pp_cycles;
  bit rdy_fixed;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_if.valid = 1'b0;
    in_if.last  = 1'b0;
    in_if.data  = 32'h0000_0000;
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input logic l);
    in_if.valid = 1'b1;
    in_if.data  = d;
    in_if.last  = l;
  endtask

  // Drives src_q into the DUT, checks popped beats against exp_q.
  task automatic run(input int max_cyc, input bit rnd);
    int cyc = 0;
    bit stall = 1'b0;
    bit pushed, popped;
    logic [DW:0] held = '0;
    logic [DW:0] beat;
    ct_seen = 0; first_pop = -1; last_pop = -1; pp_cycles = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && cyc < max_cyc) begin
      if (!in_if.valid && src_q.size() != 0)
        in_if.valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (src_q.size() != 0) begin
        in_if.data = src_q[0][DW-1:0];
        in_if.last = src_q[0][DW];
      end
      out_if.ready = rnd ? 1'($urandom_range(0, 1)) : rdy_fixed;
      #0;
      check("occupancy", 64'(occupancy), 64'(mocc));
      check("in_ready", 64'(in_if.ready), 64'(mocc != DEPTH));
      if (stall) begin
        check("stall_valid", 64'(out_if.valid), 64'd1);
        check("stall_data", 64'({out_if.last, out_if.data}), 64'(held));
      end
      if (cut_through) ct_seen++;
      pushed = in_if.valid && in_if.ready;
      popped = out_if.valid && out_if.ready;
      if (popped) begin
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        if (exp_q.size() == 0) begin
          check("pop_on_empty", 64'(out_if.valid), 64'd0);
        end else begin
          beat = exp_q.pop_front();
          check("pop_beat", 64'({out_if.last, out_if.data}), 64'(beat));
        end
      end
      stall = out_if.valid && !out_if.ready;
      held  = {out_if.last, out_if.data};
      if (pushed) exp_q.push_back(src_q.pop_front());
      if (pushed && popped) pp_cycles++;
      mocc = mocc + int'(pushed) - int'(popped);
      tick();
      if (pushed) in_if.valid = 1'b0;
      cyc++;
    end
    check("run_drained", 64'(exp_q.size() + src_q.size()), 64'd0);
    idle();
    out_if.ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    out_if.ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int len;
    do_reset();
    // reset state
    check("rst_out_valid", 64'(out_if.valid), 64'd0);
    check("rst_in_ready", 64'(in_if.ready), 64'd1);
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_bursts", 64'(bursts_stored), 64'd0);
    check("rst_ct", 64'(cut_through), 64'd0);

    // 3-beat burst A,B,C with ready=1
    out_if.ready = 1'b1;
    push_beat(32'hA000_000A, 1'b0); #0;
    check("b3_valid_a", 64'(out_if.valid), 64'd0);
    tick();
    push_beat(32'hB000_000B, 1'b0); #0;
    check("b3_valid_b", 64'(out_if.valid), 64'd0);
    tick();
    push_beat(32'hC000_000C, 1'b1); #0;
    check("b3_valid_c", 64'(out_if.valid), 64'd0);
    tick();
    idle(); #0;
    check("b3_bursts1", 64'(bursts_stored), 64'd1);
    check("b3_out_a", 64'({out_if.valid, out_if.last, out_if.data}), {31'd0, 1'b1, 1'b0, 32'hA000_000A});
    tick();
    check("b3_out_b", 64'({out_if.valid, out_if.last, out_if.data}), {31'd0, 1'b1, 1'b0, 32'hB000_000B});
    tick();
    check("b3_out_c", 64'({out_if.valid, out_if.last, out_if.data}), {31'd0, 1'b1, 1'b1, 32'hC000_000C});
    tick();
    check("b3_valid_end", 64'(out_if.valid), 64'd0);
    check("b3_bursts0", 64'(bursts_stored), 64'd0);

    // two 4-beat bursts with ready=0, then release
    out_if.ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push_beat(32'h0000_0100 + 32'(i), (i == 3 || i == 7));
      tick();
    end
    idle(); #0;
    check("b8_occ", 64'(occupancy), 64'd8);
    check("b8_bursts", 64'(bursts_stored), 64'd2);
    out_if.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #0;
      check("b8_out", 64'({out_if.valid, out_if.last, out_if.data}),
            {31'd0, 1'b1, 1'((i == 3) || (i == 7)), 32'h0000_0100 + 32'(i)});
      tick();
    end
    out_if.ready = 1'b0; #0;
    check("b8_occ_end", 64'(occupancy), 64'd0);
    check("b8_bursts_end", 64'(bursts_stored), 64'd0);

    // 20-beat oversized burst forces cut-through
    for (int i = 0; i < 20; i++) src_q.push_back({1'(i == 19), 32'h0000_0200 + 32'(i)});
    mocc = 0; rdy_fixed = 1'b1;
    run(200, 1'b0);
    check("ct_first_pop", 64'(first_pop), 64'd17);
    check("ct_last_pop", 64'(last_pop), 64'd36);
    check("ct_cycles", 64'(ct_seen), 64'd20);
    check("ct_exit", 64'(cut_through), 64'd0);
    check("ct_bursts", 64'(bursts_stored), 64'd0);

    // fill with 1-beat bursts, then push+pop with wrap-around
    out_if.ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      push_beat(32'h0000_0300 + 32'(k), 1'b1);
      exp_q.push_back({1'b1, 32'h0000_0300 + 32'(k)});
      tick();
    end
    idle(); #0;
    check("full_occ", 64'(occupancy), 64'd16);
    check("full_bursts", 64'(bursts_stored), 64'd16);
    check("full_ready", 64'(in_if.ready), 64'd0);
    for (int k = 0; k < 40; k++) src_q.push_back({1'b1, 32'h0000_0400 + 32'(k)});
    mocc = 16;
    run(200, 1'b0);
    check("wrap_pp_cycles", 64'(pp_cycles), 64'd40);

    // reset mid-burst discards partial data
    push_beat(32'h0000_0500, 1'b0); tick();
    push_beat(32'h0000_0501, 1'b0); tick();
    idle(); #0;
    check("mid_occ2", 64'(occupancy), 64'd2);
    rst_n = 1'b0;
    tick();
    check("mid_rst_occ", 64'(occupancy), 64'd0);
    check("mid_rst_bursts", 64'(bursts_stored), 64'd0);
    check("mid_rst_valid", 64'(out_if.valid), 64'd0);
    check("mid_rst_ready", 64'(in_if.ready), 64'd1);
    rst_n = 1'b1;
    push_beat(32'h0000_05FF, 1'b1); tick();
    idle(); out_if.ready = 1'b1; #0;
    check("mid_fresh", 64'({out_if.valid, out_if.last, out_if.data}), {31'd0, 1'b1, 1'b1, 32'h0000_05FF});
    tick();
    check("mid_fresh_gone", 64'(out_if.valid), 64'd0);
    out_if.ready = 1'b0;

    // random traffic on both sides
    do_reset();
    for (int b = 0; b < 1000; b++) begin
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) src_q.push_back({1'(i == len - 1), 32'($urandom)});
    end
    mocc = 0;
    run(60000, 1'b1);
    check("rnd_bursts_end", 64'(bursts_stored), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/burst_store_fwd_fifo.md
BURST_STORE_FWD_FIFO -- requirements
Module: burst_store_fwd_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, storage entries; power of two, >= 2.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, payload width of one beat.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_burst  decoupled_burst_intr.slave  valid/ready/last/data[DATA_WIDTH]  beat stream from the round-robin locking arbiter output.
REQ-006 SHALL have port out_burst  decoupled_burst_intr.master  valid/ready/last/data[DATA_WIDTH]  store-and-forward beat stream to the consumer.
REQ-007 SHALL have port occupancy  output  $clog2(DEPTH+1)  beats currently stored.
REQ-008 SHALL have port bursts_stored  output  $clog2(DEPTH+1)  complete bursts (last beat stored) not yet fully drained.
REQ-009 SHALL have port cut_through  output  1  high while in CUT_THROUGH state.

Function
REQ-010 SHALL store each accepted beat as {last,data} in a circular buffer; push = in_burst.valid && in_burst.ready.
REQ-011 SHALL drive in_burst.ready = (occupancy != DEPTH), combinational from registered count only (no valid-to-ready path).
REQ-012 SHALL drive out_burst.data/last from the entry at the read pointer; pop = out_burst.valid && out_burst.ready.
REQ-013 SHALL implement FSM states STORE and CUT_THROUGH.
REQ-014 In STORE, out_burst.valid SHALL equal (bursts_stored != 0): no beat leaves before its burst's last beat is stored.
REQ-015 Latency: a last beat pushed in cycle N SHALL make out_burst.valid high in cycle N+1 (empty buffer, STORE).
REQ-016 STORE -> CUT_THROUGH SHALL occur when occupancy == DEPTH and bursts_stored == 0 (oversized burst; deadlock avoidance).
REQ-017 In CUT_THROUGH, out_burst.valid SHALL equal (occupancy != 0); CUT_THROUGH -> STORE on pop of a beat with last=1.
REQ-018 bursts_stored SHALL increment on push with last=1, decrement on pop with last=1 while in STORE, unchanged when both occur in one cycle; in CUT_THROUGH the popped last beat SHALL NOT decrement it (that burst never counted).
REQ-019 occupancy SHALL +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-020 Simultaneous push and pop when full SHALL NOT occur (ready low when full); when empty, pop impossible (valid low).
REQ-021 Pointers SHALL wrap modulo DEPTH with no bubble at wrap-around.
REQ-022 out_burst.data/last SHALL remain stable while out_burst.valid && !out_burst.ready.
REQ-023 Beat order SHALL be preserved exactly; no beat dropped or duplicated.

Reset
REQ-024 On rst_n low at a clock edge: pointers, occupancy, bursts_stored = 0; state = STORE; cut_through = 0.
REQ-025 During/after reset out_burst.valid = 0, in_burst.ready = 1 in the first cycle after rst_n high; storage contents need no reset.
REQ-026 Reset mid-burst SHALL discard all stored beats, including partial bursts.

Structure
REQ-027 State enum (STORE, CUT_THROUGH) SHALL live in shared package burst_pkg; parameters remain module-local.
REQ-028 Storage SHALL be a sub-module burst_fifo_mem (DEPTH x (DATA_WIDTH+1), 1 write port, asynchronous read port).

Verification
REQ-029 Burst of 3 beats (A,B,C last), out ready=1, DEPTH=16 -> out valid low until cycle after C pushed, then A,B,C on 3 consecutive cycles; bursts_stored 1 -> 0.
REQ-030 Two 4-beat bursts back-to-back, out ready=0 -> occupancy=8, bursts_stored=2; release ready -> 8 beats in order, last on beats 4 and 8.
REQ-031 20-beat burst, DEPTH=16, out ready=1 -> after 16th push cut_through=1, beats flow with no loss, cut_through=0 after beat 20 pops.
REQ-032 Fill to full with 1-beat bursts, then push+pop every cycle for 40 cycles -> in ready stays 1 except when full, pointers wrap, data order intact.
REQ-033 Reset asserted after 2 of 5 beats pushed -> next cycle occupancy=0, bursts_stored=0, out valid=0, in ready=1.
REQ-034 Random valid/ready (50%) on both sides, 1000 bursts of length 1-8 -> scoreboard match, out data stable under backpressure.
